// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS run-time parameter controller.
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PEND   = 2'b01,
        ST_COMMIT = 2'b10
    } state_e;

    localparam logic [1:0] WAVE_SINE   = 2'b00;
    localparam logic [1:0] WAVE_SQUARE = 2'b01;
    localparam logic [1:0] WAVE_TRI    = 2'b10;
    localparam logic [1:0] WAVE_SAW    = 2'b11;
    localparam logic [1:0] WAVE_RST    = WAVE_SQUARE;

    // Waveform cycles sine -> square -> triangle -> sawtooth -> sine.
    function automatic logic [1:0] wave_next(input logic [1:0] w);
        return w + 2'b01;
    endfunction

endpackage

// File: rtl/key_filter.sv
// Key synchroniser + debounce producing one press pulse per press.
// With DDS_KEY_REPEAT_EN defined, a held key re-fires every REPEAT_CNT cycles.
module key_filter
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned CNT_MAX = 999_999
`ifdef DDS_KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CNT = 24_999_999,
    parameter bit          REPEAT_EN  = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    logic [1:0]       sync_q;
    logic             key_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             first_c;
    logic             fire_c;
    logic             press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign key_s = sync_q[1];

    // Counter clears while released, saturates at CNT_MAX while held.
    always_comb begin
        cnt_d = cnt_q;
        if (key_s) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign first_c = !key_s && (cnt_q == CNT_W'(CNT_MAX - 1));

`ifdef DDS_KEY_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CNT + 1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
    logic             held_c;
    logic             rep_fire_c;

    assign held_c     = REPEAT_EN && !key_s && (cnt_q == CNT_W'(CNT_MAX));
    assign rep_fire_c = held_c && (rep_q == REP_W'(REPEAT_CNT - 1));

    always_comb begin
        rep_d = '0;
        if (held_c && !rep_fire_c) begin
            rep_d = rep_q + REP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign fire_c = first_c | rep_fire_c;
`else
    assign fire_c = first_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= fire_c;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/dds_param_ctrl.sv
// DDS parameter controller: key presses stage shadow values, committed on acc_wrap or timeout.
// Optional DDS_KEY_REPEAT_EN enables auto-repeat on the frequency and phase keys.
module dds_param_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned CNT_MAX    = 999_999,
    parameter int unsigned FWORD_W    = 32,
    parameter int unsigned PHASE_W    = 12,
    parameter int unsigned FWORD_BASE = 85_899,
    parameter int unsigned FREQ_STEPS = 10,
    parameter int unsigned PHASE_STEP = 1024,
    parameter int unsigned TIMEOUT    = 4_194_303
`ifdef DDS_KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CNT = 24_999_999
`endif
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               fre_adjust,
    input  logic               pha_adjust,
    input  logic               mode_key,
    input  logic               acc_wrap,
    output logic [FWORD_W-1:0] freq_word,
    output logic [PHASE_W-1:0] phase_off,
    output logic [1:0]         wave_sel,
    output logic               param_upd,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(FREQ_STEPS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic fre_press;
    logic pha_press;
    logic mode_press;
    logic any_press;

`ifdef DDS_KEY_REPEAT_EN
    key_filter #(.CNT_MAX(CNT_MAX), .REPEAT_CNT(REPEAT_CNT), .REPEAT_EN(1'b1)) u_kf_fre (
        .clk(sys_clk), .rst_n(sys_rst_n), .key_n_i(fre_adjust), .press_o(fre_press));
    key_filter #(.CNT_MAX(CNT_MAX), .REPEAT_CNT(REPEAT_CNT), .REPEAT_EN(1'b1)) u_kf_pha (
        .clk(sys_clk), .rst_n(sys_rst_n), .key_n_i(pha_adjust), .press_o(pha_press));
    key_filter #(.CNT_MAX(CNT_MAX), .REPEAT_CNT(REPEAT_CNT), .REPEAT_EN(1'b0)) u_kf_mode (
        .clk(sys_clk), .rst_n(sys_rst_n), .key_n_i(mode_key), .press_o(mode_press));
`else
    key_filter #(.CNT_MAX(CNT_MAX)) u_kf_fre (
        .clk(sys_clk), .rst_n(sys_rst_n), .key_n_i(fre_adjust), .press_o(fre_press));
    key_filter #(.CNT_MAX(CNT_MAX)) u_kf_pha (
        .clk(sys_clk), .rst_n(sys_rst_n), .key_n_i(pha_adjust), .press_o(pha_press));
    key_filter #(.CNT_MAX(CNT_MAX)) u_kf_mode (
        .clk(sys_clk), .rst_n(sys_rst_n), .key_n_i(mode_key), .press_o(mode_press));
`endif

    assign any_press = fre_press | pha_press | mode_press;

    state_e             state_q;
    state_e             state_d;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   tmo_d;
    logic               commit_c;

    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [FWORD_W-1:0] sh_fword_q;
    logic [FWORD_W-1:0] sh_fword_d;
    logic [PHASE_W-1:0] sh_phase_q;
    logic [PHASE_W-1:0] sh_phase_d;
    logic [1:0]         sh_wave_q;
    logic [1:0]         sh_wave_d;

    logic [FWORD_W-1:0] freq_word_q;
    logic [PHASE_W-1:0] phase_off_q;
    logic [1:0]         wave_sel_q;
    logic               param_upd_q;
    logic               busy_q;

    // Commit FSM; the timeout only runs while a change is pending.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (any_press) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (acc_wrap || (tmo_q == TMO_W'(TIMEOUT))) begin
                    state_d = ST_COMMIT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_COMMIT: begin
                tmo_d   = '0;
                state_d = any_press ? ST_PEND : ST_IDLE;
            end
            default: begin
                tmo_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign commit_c = (state_q == ST_COMMIT);

    // Shadow staging; the frequency word tracks the index by accumulation.
    always_comb begin
        idx_d      = idx_q;
        sh_fword_d = sh_fword_q;
        sh_phase_d = sh_phase_q;
        sh_wave_d  = sh_wave_q;
        if (fre_press) begin
            if (idx_q == IDX_W'(FREQ_STEPS)) begin
                idx_d      = IDX_W'(1);
                sh_fword_d = FWORD_W'(FWORD_BASE);
            end else begin
                idx_d      = idx_q + IDX_W'(1);
                sh_fword_d = sh_fword_q + FWORD_W'(FWORD_BASE);
            end
        end
        if (pha_press) begin
            sh_phase_d = sh_phase_q + PHASE_W'(PHASE_STEP);
        end
        if (mode_press) begin
            sh_wave_d = wave_next(sh_wave_q);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            idx_q      <= IDX_W'(1);
            sh_fword_q <= FWORD_W'(FWORD_BASE);
            sh_phase_q <= '0;
            sh_wave_q  <= WAVE_RST;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            sh_fword_q <= sh_fword_d;
            sh_phase_q <= sh_phase_d;
            sh_wave_q  <= sh_wave_d;
        end
    end

    // Outputs take the shadow on the same edge that raises param_upd.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            freq_word_q <= FWORD_W'(FWORD_BASE);
            phase_off_q <= '0;
            wave_sel_q  <= WAVE_RST;
            param_upd_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (commit_c) begin
                freq_word_q <= sh_fword_q;
                phase_off_q <= sh_phase_q;
                wave_sel_q  <= sh_wave_q;
            end
            param_upd_q <= commit_c;
            busy_q      <= (state_d == ST_PEND);
        end
    end

    assign freq_word = freq_word_q;
    assign phase_off = phase_off_q;
    assign wave_sel  = wave_sel_q;
    assign param_upd = param_upd_q;
    assign busy      = busy_q;

endmodule
